// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add unsigned multiplier controller that borrows the
// shared combinational ALU for one add per cycle, one multiplier bit per cycle.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, mcand, mplier  multiply request and operands (captured on accept)
//   busy, done            busy in RUN/DONE; done pulses for the DONE cycle
//   product_hi/lo         running {hi,lo} register pair, final from DONE on
//   alu_sel/in0/in1       drive the shared ALU
//   alu_out               ALU result, same cycle
module alu_mul_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CNT_W   = 5,
    parameter logic [2:0]  ALU_ADD = 3'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [2:0]       alu_sel,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_out
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [WIDTH-1:0]   hi, hi_nxt;
    logic [WIDTH-1:0]   lo, lo_nxt;
    logic [WIDTH-1:0]   mcand_r, mcand_nxt;
    logic               carry;

    // State and datapath registers; busy/done registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            mcand_r <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            mcand_r <= mcand_nxt;
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
        end
    end

    // The ALU has no carry-out: an unsigned add wrapped iff the sum is below an addend.
    assign carry = (alu_out < hi);

    // Next-state, datapath update and ALU drive.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        hi_nxt    = hi;
        lo_nxt    = lo;
        mcand_nxt = mcand_r;
        alu_sel   = ALU_ADD;
        alu_in0   = '0;
        alu_in1   = '0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    mcand_nxt = mcand;
                    lo_nxt    = mplier;
                    hi_nxt    = '0;
                    count_nxt = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                alu_in0   = hi;
                alu_in1   = lo[0] ? mcand_r : '0;
                // {hi,lo} <= {carry, sum, lo >> 1}: sum LSB drops into lo's MSB.
                hi_nxt    = {carry, alu_out[WIDTH-1:1]};
                lo_nxt    = {alu_out[0], lo[WIDTH-1:1]};
                count_nxt = count + CNT_W'(1);
                if (count == LAST_STEP) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign product_hi = hi;
    assign product_lo = lo;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed bench for alu_mul_sequencer with a small ALU,
// an arithmetic reference model checked every cycle, and literal expectations.
module tb_alu_mul_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] mcand, mplier;
    logic        busy, done;
    logic [15:0] product_hi, product_lo;
    logic [2:0]  alu_sel;
    logic [15:0] alu_in0, alu_in1, alu_out;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    always #5 clock = ~clock;

    alu_mul_sequencer #(.WIDTH(16), .CNT_W(5), .ALU_ADD(3'd0)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mcand      (mcand),
        .mplier     (mplier),
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo),
        .alu_sel    (alu_sel),
        .alu_in0    (alu_in0),
        .alu_in1    (alu_in1),
        .alu_out    (alu_out)
    );

    // Shared ALU: 0 add, 1 sub, 2 pass in1, 3 OR, 4 AND.
    always_comb begin
        case (alu_sel)
            3'd0:    alu_out = alu_in0 + alu_in1;
            3'd1:    alu_out = alu_in0 - alu_in1;
            3'd2:    alu_out = alu_in1;
            3'd3:    alu_out = alu_in0 | alu_in1;
            3'd4:    alu_out = alu_in0 & alu_in1;
            default: alu_out = 16'h0000;
        endcase
    end

    // After k multiplier bits are consumed, {hi,lo} holds the partial product of
    // the low k bits aligned to the top, with the unconsumed bits below it.
    function automatic logic [31:0] partial(input logic [15:0] a, input logic [15:0] b, input int k);
        logic [63:0] mask;
        logic [63:0] p;
        mask = (64'd1 << k) - 64'd1;
        p = (64'(a) * (64'(b) & mask)) << (16 - k);
        p = p + (64'(b) >> k);
        return p[31:0];
    endfunction

    // Reference model: phase 0 idle, 1 run, 2 done.
    int          m_ph = 0;
    int          m_k  = 0;
    logic [15:0] m_a  = 16'h0;
    logic [15:0] m_b  = 16'h0;
    logic [31:0] m_prod = 32'h0;

    always @(posedge clock) begin
        if (reset) begin
            m_ph   <= 0;
            m_k    <= 0;
            m_a    <= 16'h0;
            m_b    <= 16'h0;
            m_prod <= 32'h0;
        end else begin
            case (m_ph)
                0: if (start) begin
                    m_a    <= mcand;
                    m_b    <= mplier;
                    m_k    <= 0;
                    m_prod <= {16'h0, mplier};
                    m_ph   <= 1;
                end
                1: begin
                    m_k    <= m_k + 1;
                    m_prod <= partial(m_a, m_b, m_k + 1);
                    if (m_k == 15) m_ph <= 2;
                end
                default: m_ph <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance to the falling edge and compare the DUT against the model.
    task automatic tick();
        @(negedge clock);
        if (armed) begin
            check("busy", 32'(busy), 32'(m_ph != 0));
            check("done", 32'(done), 32'(m_ph == 2));
            check("product", {product_hi, product_lo}, m_prod);
            if (m_ph == 1) begin
                check("run_alu_sel", 32'(alu_sel), 32'd0);
                check("run_alu_in0", 32'(alu_in0), 32'(m_prod[31:16]));
                check("run_alu_in1", 32'(alu_in1), 32'(m_b[m_k] ? m_a : 16'h0));
            end else if (m_ph == 0) begin
                check("idle_alu_sel", 32'(alu_sel), 32'd0);
                check("idle_alu_in0", 32'(alu_in0), 32'd0);
                check("idle_alu_in1", 32'(alu_in1), 32'd0);
            end
        end
    endtask

    // Issue one multiply from IDLE; optionally re-pulse start with 7*7 at RUN cycle 'inject'.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int inject,
                           input logic [31:0] exp_prod, input string name);
        int n;
        int busy_n;
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        tick();
        start  = 1'b0;
        mcand  = 16'hDEAD;
        mplier = 16'hBEEF;
        n      = 1;
        busy_n = int'(busy);
        while (!done && n < 40) begin
            if (inject != 0 && n == inject) begin
                start  = 1'b1;
                mcand  = 16'h0007;
                mplier = 16'h0007;
            end else begin
                start  = 1'b0;
            end
            tick();
            n++;
            busy_n += int'(busy);
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(n), 32'd17);
        check({name, "_busy_cycles"}, 32'(busy_n), 32'd17);
        check({name, "_product"}, {product_hi, product_lo}, exp_prod);
        tick();
        check({name, "_hold"}, {product_hi, product_lo}, exp_prod);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int dn;
        int d1;
        int d2;
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = 16'h0;
        mplier = 16'h0;
        @(posedge clock);
        @(posedge clock);
        armed = 1'b1;
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", {product_hi, product_lo}, 32'h0000_0000);
        reset = 1'b0;
        tick();

        run_mul(16'h0003, 16'h0005, 0, 32'h0000_000F, "mul_3x5");
        run_mul(16'hFFFF, 16'hFFFF, 0, 32'hFFFE_0001, "mul_max");
        run_mul(16'h1234, 16'h0000, 0, 32'h0000_0000, "mul_zero");
        run_mul(16'h0004, 16'h0007, 5, 32'h0000_001C, "mul_ignore_start");

        // Reset in the middle of RUN discards the partial product.
        start  = 1'b1;
        mcand  = 16'h0009;
        mplier = 16'h0009;
        tick();
        start  = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_product", {product_hi, product_lo}, 32'h0000_0000);
        reset = 1'b0;
        tick();
        run_mul(16'h0002, 16'h0008, 0, 32'h0000_0010, "mul_after_reset");

        // Start held high: re-accepted in the IDLE cycle after DONE.
        start  = 1'b1;
        mcand  = 16'h0005;
        mplier = 16'h0006;
        n  = 0;
        dn = 0;
        d1 = 0;
        d2 = 0;
        while (dn < 2 && n < 60) begin
            tick();
            n++;
            if (done) begin
                dn++;
                if (dn == 1) d1 = n;
                else d2 = n;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(dn), 32'd2);
        check("b2b_gap", 32'(d2 - d1), 32'd18);
        check("b2b_product", {product_hi, product_lo}, 32'h0000_001E);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
